// File: rtl/fetch_unit_pkg.sv
// Constants shared between fetch, decode and the ROM image builder.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;

  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_J    = 6'h28;

  localparam int unsigned OPCODE_MSB   = 31;
  localparam int unsigned OPCODE_LSB   = 26;
  localparam int unsigned J_TARGET_MSB = 25;
  localparam int unsigned J_TARGET_LSB = 0;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } fetch_state_e;

  function automatic logic [5:0] get_opcode(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational predecode: spots unconditional jumps and picks the next PC.
module fetch_predecode
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       rom_data,
  output logic              is_jump,
  output logic [ADDR_W-1:0] next_pc
);

  logic [J_TARGET_MSB-J_TARGET_LSB:0] j_target;
  logic                               unused_target;

  always_comb begin
    j_target = rom_data[J_TARGET_MSB:J_TARGET_LSB];
    is_jump  = (get_opcode(rom_data) == OP_J);
    // Target bits above the PC width are dropped.
    next_pc  = is_jump ? j_target[ADDR_W-1:0] : pc + ADDR_W'(1);
  end

  assign unused_target = ^j_target;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, follows J via predecode and
// presents each fetched word in a single-entry valid/ready slot.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] slot_pc_q, slot_pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;

  logic              run;
  logic              slot_free;
  logic              capture;
  logic [ADDR_W-1:0] next_pc;
  logic              unused_is_jump;

  fetch_predecode #(
    .ADDR_W (ADDR_W)
  ) u_predecode (
    .pc       (pc_q),
    .rom_data (rom_data),
    .is_jump  (unused_is_jump),
    .next_pc  (next_pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirects never touch the state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (fetch_en)  state_d = StRun;
      StRun:   if (!fetch_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    run       = (state_q == StRun);
    rom_addr  = pc_q;
    out_valid = valid_q;
    out_instr = instr_q;
    out_pc    = slot_pc_q;
  end

  // PC and slot next-state; redirect wins over capture and over acceptance
  always_comb begin
    slot_free = !valid_q || out_ready;
    capture   = run && !redirect_valid && slot_free;
    pc_d      = pc_q;
    slot_pc_d = slot_pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
    end else if (capture) begin
      pc_d      = next_pc;
      slot_pc_d = pc_q;
      instr_d   = rom_data;
      valid_d   = 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      slot_pc_q <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      slot_pc_q <= slot_pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the word-addressed instruction ROM. It owns the program counter, drives the ROM address, and registers each returned word into a single-entry output slot with a valid/ready handshake to decode. It follows unconditional jumps (opcode 0x28) itself through predecode, and it accepts redirects from execute. It sits between the instruction ROM and the decode stage.

## Interface
- `ADDR_W`, default 10: ROM word-address width, which is also the PC width.
- `RESET_PC`, default 0: PC value loaded at reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `fetch_en`  in  1: run enable; level-sensitive.
- `rom_addr`  out  ADDR_W: word address to ROM; always equals the PC register.
- `rom_data`  in  32: ROM word for `rom_addr`; combinational, valid in the same cycle.
- `redirect_valid`  in  1: single-cycle pulse from execute to change the PC.
- `redirect_pc`  in  ADDR_W: new word address; used only while `redirect_valid` = 1.
- `out_valid`  out  1: output slot holds an instruction.
- `out_ready`  in  1: decode accepts the slot contents.
- `out_instr`  out  32: fetched instruction word.
- `out_pc`  out  ADDR_W: word address `out_instr` was fetched from.

## Operation
- FSM has two states: IDLE and RUN.
  - IDLE → RUN when `fetch_en` = 1.
  - RUN → IDLE when `fetch_en` = 0.
  - Reset forces IDLE.
- A capture occurs in a cycle when all three hold: state is RUN, `redirect_valid` = 0, and the slot is free. The slot is free when `out_valid` = 0, or when `out_valid` & `out_ready` = 1.
- On a capture:
  - slot ← {`rom_data`, PC}, and `out_valid` ← 1.
  - PC ← next PC.
- Next-PC rule:
  - If `rom_data[31:26]` == 6'h28, next PC = `rom_data[ADDR_W-1:0]`; imm bits above ADDR_W are ignored.
  - Otherwise, next PC = PC + 1 modulo 2^ADDR_W (1023 wraps to 0).
- A J instruction is still delivered to decode. Execute treats it as a NOP and must not redirect for it.
- If the slot is consumed (`out_valid` & `out_ready`) and there is no capture, then `out_valid` ← 0.
- Redirect has highest priority and applies in any state:
  - PC ← `redirect_pc`.
  - `out_valid` ← 0; the slot is flushed even if decode accepts in the same cycle.
  - No capture occurs in that cycle.
  - The FSM state is unchanged.
- Stall: while `out_valid` = 1 and `out_ready` = 0, the slot contents and the PC hold unchanged.
- When `fetch_en` drops, an instruction already in the slot stays valid until it is accepted. No new captures occur, and the PC is retained for resume.
- Reset values: state IDLE, PC = `RESET_PC`, `out_valid` = 0, `out_instr` = 0, `out_pc` = 0, `rom_addr` = `RESET_PC`.
- Reset asserted mid-operation discards the slot and PC on that edge, regardless of `redirect_valid` or `out_ready`.

## Timing
- Start latency: `fetch_en` is high at edge N (state → RUN). The first capture happens at edge N+1, so `out_valid` = 1 from cycle N+1 after that edge.
- Throughput: with `out_ready` held at 1, one instruction per cycle, including across taken J instructions (no bubble).
- Redirect: a redirect pulse at edge M gives `out_valid` = 0 after M. The instruction from `redirect_pc` is valid after edge M+1.
- All outputs are registered except `rom_addr`, which is the PC register driven directly.
- Decode may drop `out_ready` at any time. `out_valid` never deasserts without acceptance, except on redirect or reset.

## Structure
- Shared package holds:
  - `OP_ADDI` = 6'h10 and `OP_J` = 6'h28.
  - Default `ADDR_W` = 10.
  - The opcode field position [31:26].
  - The J target field [25:0].
- These constants are shared with the ROM image builder and with decode.
- One natural sub-module: `fetch_predecode`, combinational. Its inputs are PC and `rom_data`; its outputs are `is_jump` and `next_pc`.
- FSM, PC, and slot registers stay in `fetch_unit`.

## Test plan
- Reset, then free run with `fetch_en` = 1 and `out_ready` = 1 on a three-word program: word 0 = 0x40210001 (ADDI r1,r1,1), word 1 = 0x40420002 (ADDI r2,r2,2), word 2 = 0xA0000000 (J 0). Required `out_pc` sequence: 0, 1, 2, 0, 1, 2… with matching `out_instr`, one per cycle, no gaps.
- Backpressure: hold `out_ready` = 0 for 3 cycles while the slot holds pc=1. Required: `out_valid`, `out_pc` = 1 and `out_instr` = 0x40420002 stable, `rom_addr` = 2 stable. After release, the next item is pc=2.
- Redirect while stalled: slot valid at pc=1, `out_ready` = 0, then a `redirect_valid` pulse with `redirect_pc` = 5. Required: `out_valid` = 0 for one cycle, then `out_pc` = 5; the pc=1 word is never accepted.
- Wrap: `redirect_pc` = 1023 with ROM word 1023 = 0 (NOP). Required: `out_pc` = 1023 followed by 0.
- Jump truncation: ROM word 0 = 0xA3FFFC07 (J, imm26 = 0x3FFFC07). Required: next `out_pc` = 0x007 (imm26[9:0]).
- `fetch_en` dropped with the slot valid and `out_ready` = 0, and reset mid-run. Required:
  - The slot holds until accepted, then `out_valid` = 0, and nothing more is fetched.
  - Re-enable resumes at the retained PC.
  - `rst_n` = 0 with `redirect_valid` = 1 yields `out_valid` = 0, PC = 0, IDLE.
